sliding_window: RTL and testbench

SLIDING_WINDOW -- requirements
Module: sliding_window

---
 rtl/cv_pkg.sv | 18 +
 rtl/sliding_window_line_buffer.sv | 34 +++
 rtl/sliding_window.sv | 182 ++++++++++++++++++
 tb/tb_sliding_window.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv_pkg
// Description : Shared vision-pipeline types and default frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package cv_pkg;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int c_LINE_WIDTH_DEFAULT   = 160;
    localparam int c_IMAGE_HEIGHT_DEFAULT = 120;

endpackage
`default_nettype wire

// File: rtl/sliding_window_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Enable-gated shift line; data_o is the input Depth accepts ago.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
    import cv_pkg::*;
#(
    parameter int Depth = c_LINE_WIDTH_DEFAULT,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    // Contents are always overwritten before being observed, so no reset.
    logic [Width-1:0] r_mem [Depth];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_mem[0] <= data_i;
            for (int i = 1; i < Depth; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign data_o = r_mem[Depth-1];

endmodule
`default_nettype wire

// File: rtl/sliding_window.sv
`default_nettype none
// ============================================================================
// Module      : sliding_window
// Description : KxK raster window generator (valid convolution, no padding).
//               Define SLIDING_WINDOW_LAST_EN to add last_o (final window).
// Revision    : 1.0 - initial release
// ============================================================================
module sliding_window
    import cv_pkg::*;
#(
    parameter int KernelWidth = 3,
    parameter int WidthIn     = 1,
    parameter int LineWidth   = c_LINE_WIDTH_DEFAULT,
    parameter int ImageHeight = c_IMAGE_HEIGHT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic [WidthIn-1:0] data_i,
    output logic ready_o,
    output logic valid_o,
    output logic [KernelWidth*KernelWidth-1:0][WidthIn-1:0] window_o,
    input  logic ready_i
`ifdef SLIDING_WINDOW_LAST_EN
    ,
    output logic last_o
`endif
);

    localparam int KernelArea = KernelWidth * KernelWidth;
    localparam int c_COL_W = (LineWidth > 1) ? $clog2(LineWidth) : 1;
    localparam int c_ROW_W = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST      = c_COL_W'(LineWidth - 1);
    localparam logic [c_COL_W-1:0] c_COL_FIRST_WIN = c_COL_W'(KernelWidth - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST      = c_ROW_W'(ImageHeight - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_FILL_LAST = c_ROW_W'(KernelWidth - 2);

    state_t                             r_state;
    state_t                             w_state_next;
    logic [c_COL_W-1:0]                 r_col;
    logic [c_ROW_W-1:0]                 r_row;
    logic                               r_valid;
    logic [KernelArea-1:0][WidthIn-1:0] r_window;
    logic [KernelArea-1:0][WidthIn-1:0] w_window_next;
    logic                               w_accept;
    logic                               w_xfer;
    logic                               w_emit;
    logic                               w_col_last;
    logic                               w_frame_last;
    logic [WidthIn-1:0]                 w_lb_out  [KernelWidth-1];
    logic [WidthIn-1:0]                 w_column  [KernelWidth];
    logic [WidthIn-1:0]                 r_sr      [KernelWidth][KernelWidth];
    logic [WidthIn-1:0]                 w_sr_next [KernelWidth][KernelWidth];

    assign ready_o      = !r_valid || ready_i;
    assign w_accept     = valid_i && ready_o;
    assign w_xfer       = r_valid && ready_i;
    assign w_col_last   = (r_col == c_COL_LAST);
    assign w_frame_last = w_col_last && (r_row == c_ROW_LAST);

    // Line buffers are chained: buffer i delays the stream by (i+1) rows.
    genvar gi;
    generate
        for (gi = 0; gi < KernelWidth - 1; gi++) begin : g_lb
            logic [WidthIn-1:0] w_in;
            if (gi == 0) begin : g_first
                assign w_in = data_i;
            end else begin : g_chain
                assign w_in = w_lb_out[gi-1];
            end
            line_buffer #(
                .Depth (LineWidth),
                .Width (WidthIn)
            ) u_lb (
                .clk_i  (clk_i),
                .en_i   (w_accept),
                .data_i (w_in),
                .data_o (w_lb_out[gi])
            );
        end

        for (gi = 0; gi < KernelWidth; gi++) begin : g_col
            if (gi == KernelWidth - 1) begin : g_newest
                assign w_column[gi] = data_i;
            end else begin : g_buffered
                assign w_column[gi] = w_lb_out[KernelWidth-2-gi];
            end
        end
    endgenerate

    always_comb begin
        w_sr_next     = r_sr;
        w_window_next = '0;
        for (int r = 0; r < KernelWidth; r++) begin
            for (int c = 0; c < KernelWidth - 1; c++) begin
                w_sr_next[r][c] = r_sr[r][c+1];
            end
            w_sr_next[r][KernelWidth-1] = w_column[r];
        end
        for (int r = 0; r < KernelWidth; r++) begin
            for (int c = 0; c < KernelWidth; c++) begin
                w_window_next[r*KernelWidth+c] = w_sr_next[r][c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_sr <= w_sr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_accept && w_col_last && (r_row == c_ROW_FILL_LAST)) w_state_next = ACTIVE;
            ACTIVE:  if (w_accept && w_frame_last) w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    // Columns left of K-1 still hold the previous row, so they gate emission.
    always_comb begin
        w_emit = 1'b0;
        if (r_state == ACTIVE) begin
            w_emit = w_accept && (r_col >= c_COL_FIRST_WIN);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_window <= '0;
        end else if (w_emit) begin
            r_valid  <= 1'b1;
            r_window <= w_window_next;
        end else if (w_xfer) begin
            r_valid  <= 1'b0;
        end
    end

    assign valid_o  = r_valid;
    assign window_o = r_window;

`ifdef SLIDING_WINDOW_LAST_EN
    logic r_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= 1'b0;
        end else if (w_emit) begin
            r_last <= w_frame_last;
        end
    end

    assign last_o = r_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sliding_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_sliding_window
// Description : Directed ramp-frame bench for sliding_window (K=3, 5x4, 8 bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sliding_window;

    localparam int c_K    = 3;
    localparam int c_W    = 8;
    localparam int c_LW   = 5;
    localparam int c_IH   = 4;
    localparam int c_AREA = c_K * c_K;

    localparam logic [71:0] c_WIN12 = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] c_WIN17 = {8'd17, 8'd16, 8'd15, 8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5};
    localparam logic [71:0] c_WIN19 = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};

    logic clk_i = 1'b0;
    logic rst_i;
    logic valid_i;
    logic [c_W-1:0] data_i;
    logic ready_o;
    logic valid_o;
    logic [c_AREA-1:0][c_W-1:0] window_o;
    logic ready_i;
`ifdef SLIDING_WINDOW_LAST_EN
    logic last_o;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int n_windows = 0;

    always #5 clk_i = ~clk_i;

    sliding_window #(
        .KernelWidth (c_K),
        .WidthIn     (c_W),
        .LineWidth   (c_LW),
        .ImageHeight (c_IH)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .window_o (window_o),
        .ready_i  (ready_i)
`ifdef SLIDING_WINDOW_LAST_EN
        ,
        .last_o   (last_o)
`endif
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window ending at ramp pixel p: element r*3+c is pixel p-(2-r)*5-(2-c).
    function automatic logic [71:0] exp_win(input int p);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < c_K; r++) begin
            for (int c = 0; c < c_K; c++) begin
                w[(r*c_K+c)*c_W +: c_W] = 8'(p - (c_K-1-r)*c_LW - (c_K-1-c));
            end
        end
        return w;
    endfunction

    function automatic logic exp_valid(input int p);
        return ((p / c_LW) >= c_K - 1) && ((p % c_LW) >= c_K - 1);
    endfunction

    task automatic push(input string tag, input int p);
        valid_i = 1'b1;
        data_i  = 8'(p);
        @(negedge clk_i);
        check($sformatf("%s p%0d valid_o", tag, p), 72'(valid_o), 72'(exp_valid(p)));
        if (exp_valid(p)) begin
            n_windows++;
            check($sformatf("%s p%0d window_o", tag, p), window_o, exp_win(p));
`ifdef SLIDING_WINDOW_LAST_EN
            check($sformatf("%s p%0d last_o", tag, p), 72'(last_o), 72'(p == 19));
`endif
        end
    endtask

    task automatic run_frame(input string tag);
        n_windows = 0;
        for (int p = 0; p < c_LW * c_IH; p++) begin
            push(tag, p);
        end
        valid_i = 1'b0;
        check({tag, " window count"}, 72'(n_windows), 72'd6);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_i);
        rst_i   = 1'b1;
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_i   = 1'b0;
        check({tag, " valid_o"}, 72'(valid_o), 72'd0);
        check({tag, " window_o"}, window_o, 72'd0);
        check({tag, " ready_o"}, 72'(ready_o), 72'd1);
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("reset valid_o", 72'(valid_o), 72'd0);
        check("reset window_o", window_o, 72'd0);
        check("reset ready_o", 72'(ready_o), 72'd1);

        // Ramp with the downstream always ready, plus row-boundary literals.
        n_windows = 0;
        for (int p = 0; p < 20; p++) begin
            push("ramp", p);
            if (p == 12) check("ramp first window", window_o, c_WIN12);
            if (p == 17) check("ramp window after row wrap", window_o, c_WIN17);
            if (p == 19) check("ramp last window", window_o, c_WIN19);
        end
        valid_i = 1'b0;
        check("ramp window count", 72'(n_windows), 72'd6);
        @(negedge clk_i);
        check("ramp valid_o drains", 72'(valid_o), 72'd0);

        // Two frames back to back; frame 2 must refill before emitting.
        do_reset("frames reset");
        run_frame("frame1");
        run_frame("frame2");

        // Stall on the first window for three cycles.
        do_reset("stall reset");
        for (int p = 0; p < 12; p++) push("stall", p);
        ready_i = 1'b0;
        push("stall", 12);
        data_i = 8'd13;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check($sformatf("stall c%0d valid_o", i), 72'(valid_o), 72'd1);
            check($sformatf("stall c%0d window_o", i), window_o, c_WIN12);
            check($sformatf("stall c%0d ready_o", i), 72'(ready_o), 72'd0);
        end
        ready_i = 1'b1;
        for (int p = 13; p < 20; p++) push("stall", p);
        valid_i = 1'b0;

        // Reset in mid-frame, then a clean ramp.
        do_reset("midreset pre");
        for (int p = 0; p < 14; p++) push("midreset", p);
        do_reset("midreset post");
        run_frame("restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
